// File: rtl/ncl_inj_pkg.sv
// Shared types and dual-rail encoding helpers for the NCL operand injector.
package ncl_inj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_NULL = 2'd2
    } inj_state_e;

    // Digit layout is {rail1, rail0}; rail1 asserts a one, rail0 asserts a zero.
    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_ZERO = 2'b01;
    localparam logic [1:0] DR_ONE  = 2'b10;

    function automatic logic [1:0] dr_encode_bit(input logic bit_i);
        return bit_i ? DR_ONE : DR_ZERO;
    endfunction

endpackage

// File: rtl/ncl_ack_sync.sv
// Multi-flop synchroniser bringing the asynchronous NCL completion into clk.
module ncl_ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic init_n,
    input  logic ack_in,
    output logic ack_s
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("ncl_ack_sync: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ncl_operand_injector.sv
// Clocked-to-NCL boundary: 2-entry operand FIFO driving DATA/NULL wavefronts.
// Optional watchdog enabled by defining NCL_INJ_TIMEOUT_EN.
module ncl_operand_injector
    import ncl_inj_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_cin,
    output logic [2*WIDTH-1:0] a_dr,
    output logic [2*WIDTH-1:0] b_dr,
    output logic [1:0]         cin_dr,
    input  logic               ack_in,
    output logic               busy,
    output logic               err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ncl_operand_injector: TIMEOUT_CYCLES must be at least 1");
    end

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } word_t;

    logic ack_s;

    ncl_ack_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .init_n(init_n),
        .ack_in(ack_in),
        .ack_s (ack_s)
    );

    // Operand FIFO
    word_t      fifo_q [2];
    word_t      word_in;
    word_t      head;
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q, count_d;
    logic       fifo_empty, fifo_full, push, pop;

    assign word_in.a   = in_a;
    assign word_in.b   = in_b;
    assign word_in.cin = in_cin;
    assign head        = fifo_q[rd_ptr_q];
    assign fifo_empty  = (count_q == 2'd0);
    assign fifo_full   = (count_q == 2'd2);
    assign in_ready    = !fifo_full;
    assign push        = in_valid && !fifo_full;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= word_in;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= !wr_ptr_q;
            if (pop)  rd_ptr_q <= !rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Dual-rail image of the FIFO head, ready to be latched onto the rails.
    logic [2*WIDTH-1:0] head_a_dr, head_b_dr;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
        assign head_a_dr[2*gi +: 2] = dr_encode_bit(head.a[gi]);
        assign head_b_dr[2*gi +: 2] = dr_encode_bit(head.b[gi]);
    end

    // Wavefront FSM
    inj_state_e         state_q, state_d;
    logic [2*WIDTH-1:0] a_dr_q, a_dr_d, b_dr_q, b_dr_d;
    logic [1:0]         cin_dr_q, cin_dr_d;
    logic               load_data, load_null;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        load_data = 1'b0;
        load_null = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !ack_s) begin
                    pop       = 1'b1;
                    load_data = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (ack_s) begin
                    load_null = 1'b1;
                    state_d   = ST_NULL;
                end
            end
            ST_NULL: begin
                if (!ack_s) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        load_data = 1'b1;
                        state_d   = ST_DATA;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_dr_d   = a_dr_q;
        b_dr_d   = b_dr_q;
        cin_dr_d = cin_dr_q;
        if (load_data) begin
            a_dr_d   = head_a_dr;
            b_dr_d   = head_b_dr;
            cin_dr_d = dr_encode_bit(head.cin);
        end else if (load_null) begin
            a_dr_d   = '0;
            b_dr_d   = '0;
            cin_dr_d = DR_NULL;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q  <= ST_IDLE;
            a_dr_q   <= '0;
            b_dr_q   <= '0;
            cin_dr_q <= DR_NULL;
        end else begin
            state_q  <= state_d;
            a_dr_q   <= a_dr_d;
            b_dr_q   <= b_dr_d;
            cin_dr_q <= cin_dr_d;
        end
    end

    assign a_dr   = a_dr_q;
    assign b_dr   = b_dr_q;
    assign cin_dr = cin_dr_q;
    assign busy   = (state_q != ST_IDLE) || !fifo_empty;

`ifdef NCL_INJ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             err_q;

    // Counter saturates at the limit so the flag cannot be missed by wrap-around.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                tmo_cnt_q <= '0;
            end else if (state_q != ST_IDLE && tmo_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ncl_operand_injector.sv
// Directed self-checking bench for ncl_operand_injector (SYNC_STAGES=2).
module tb_ncl_operand_injector;

    localparam int WIDTH = 4;

    logic             clk;
    logic             init_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [7:0]       a_dr;
    logic [7:0]       b_dr;
    logic [1:0]       cin_dr;
    logic             ack_in;
    logic             busy;
    logic             err;

    int checks = 0;
    int errors = 0;

    ncl_operand_injector #(
        .WIDTH         (WIDTH),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk     (clk),
        .init_n  (init_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a    (in_a),
        .in_b    (in_b),
        .in_cin  (in_cin),
        .a_dr    (a_dr),
        .b_dr    (b_dr),
        .cin_dr  (cin_dr),
        .ack_in  (ack_in),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_word(input logic [3:0] a, input logic [3:0] b, input logic c);
        in_a   = a;
        in_b   = b;
        in_cin = c;
    endtask

    // Change ack_in at a falling edge and let the synchroniser plus FSM act.
    task automatic drive_ack(input logic lvl);
        ack_in = lvl;
        wait_neg(3);
    endtask

    task automatic test_reset;
        init_n = 1'b1; in_valid = 1'b0; ack_in = 1'b0;
        set_word(4'h0, 4'h0, 1'b0);
        #2 init_n = 1'b0;
        wait_neg(2);
        checks++;
        if ({a_dr, b_dr, cin_dr} !== 18'h0) begin
            errors++; $display("FAIL reset_rails got a=%b b=%b cin=%b expected all 0", a_dr, b_dr, cin_dr);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err); end
        init_n = 1'b1;
        wait_neg(2);
    endtask

    task automatic test_single_word;
        in_valid = 1'b1; set_word(4'hA, 4'h3, 1'b0);
        wait_neg(1);
        in_valid = 1'b0;
        checks++;
        if (a_dr !== 8'h00 || busy !== 1'b1) begin
            errors++; $display("FAIL single_accept got a=%b busy=%b expected a=00000000 busy=1", a_dr, busy);
        end
        wait_neg(1);
        checks++;
        if (a_dr !== 8'b10011001 || b_dr !== 8'b01011010 || cin_dr !== 2'b01) begin
            errors++; $display("FAIL single_data got a=%b b=%b cin=%b expected 10011001 01011010 01", a_dr, b_dr, cin_dr);
        end
        wait_neg(3);
        ack_in = 1'b1;
        wait_neg(2);
        checks++;
        if (a_dr !== 8'b10011001) begin
            errors++; $display("FAIL single_hold got a=%b expected 10011001", a_dr);
        end
        wait_neg(1);
        checks++;
        if ({a_dr, b_dr, cin_dr} !== 18'h0) begin
            errors++; $display("FAIL single_null got a=%b b=%b cin=%b expected all 0", a_dr, b_dr, cin_dr);
        end
        drive_ack(1'b0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back;
        in_valid = 1'b1; set_word(4'h0, 4'hF, 1'b1);
        wait_neg(1);
        set_word(4'h5, 4'hC, 1'b0);
        wait_neg(1);
        checks++;
        if (in_ready !== 1'b1 || a_dr !== 8'b01010101) begin
            errors++; $display("FAIL push_pop_count got ready=%b a=%b expected ready=1 a=01010101", in_ready, a_dr);
        end
        set_word(4'h9, 4'h6, 1'b1);
        wait_neg(1);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got ready=%b expected 0", in_ready); end
        checks++;
        if (a_dr !== 8'b01010101 || b_dr !== 8'b10101010 || cin_dr !== 2'b10) begin
            errors++; $display("FAIL b2b_w0 got a=%b b=%b cin=%b expected 01010101 10101010 10", a_dr, b_dr, cin_dr);
        end
        set_word(4'hF, 4'hF, 1'b1);
        wait_neg(1);
        in_valid = 1'b0;
        drive_ack(1'b1);
        checks++;
        if (a_dr !== 8'h00 || in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_null0 got a=%b ready=%b expected 00000000 0", a_dr, in_ready);
        end
        drive_ack(1'b0);
        checks++;
        if (a_dr !== 8'b01100110 || b_dr !== 8'b10100101 || cin_dr !== 2'b01 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_w1 got a=%b b=%b cin=%b ready=%b expected 01100110 10100101 01 1", a_dr, b_dr, cin_dr, in_ready);
        end
        drive_ack(1'b1);
        checks++;
        if ({a_dr, b_dr, cin_dr} !== 18'h0) begin errors++; $display("FAIL b2b_null1 got a=%b expected 0", a_dr); end
        drive_ack(1'b0);
        checks++;
        if (a_dr !== 8'b10010110 || b_dr !== 8'b01101001 || cin_dr !== 2'b10) begin
            errors++; $display("FAIL b2b_w2 got a=%b b=%b cin=%b expected 10010110 01101001 10", a_dr, b_dr, cin_dr);
        end
        drive_ack(1'b1);
        drive_ack(1'b0);
        checks++;
        if (busy !== 1'b0 || a_dr !== 8'h00) begin
            errors++; $display("FAIL b2b_drained got busy=%b a=%b expected 0 00000000", busy, a_dr);
        end
    endtask

    task automatic test_ack_high_at_reset;
        ack_in = 1'b1;
        init_n = 1'b0;
        wait_neg(2);
        init_n = 1'b1;
        wait_neg(3);
        in_valid = 1'b1; set_word(4'h7, 4'h8, 1'b0);
        wait_neg(1);
        in_valid = 1'b0;
        wait_neg(4);
        checks++;
        if (a_dr !== 8'h00 || busy !== 1'b1) begin
            errors++; $display("FAIL ackhigh_wait got a=%b busy=%b expected 00000000 1", a_dr, busy);
        end
        ack_in = 1'b0;
        wait_neg(2);
        checks++;
        if (a_dr !== 8'h00) begin errors++; $display("FAIL ackhigh_early got a=%b expected 00000000", a_dr); end
        wait_neg(1);
        checks++;
        if (a_dr !== 8'b01101010 || b_dr !== 8'b10010101 || cin_dr !== 2'b01) begin
            errors++; $display("FAIL ackhigh_data got a=%b b=%b cin=%b expected 01101010 10010101 01", a_dr, b_dr, cin_dr);
        end
        drive_ack(1'b1);
        drive_ack(1'b0);
    endtask

    task automatic test_async_reset_in_data;
        in_valid = 1'b1; set_word(4'h1, 4'h2, 1'b1);
        wait_neg(1);
        set_word(4'h3, 4'h4, 1'b0);
        wait_neg(1);
        set_word(4'h5, 4'h6, 1'b1);
        wait_neg(1);
        in_valid = 1'b0;
        checks++;
        if (a_dr !== 8'b01010110 || in_ready !== 1'b0) begin
            errors++; $display("FAIL areset_pre got a=%b ready=%b expected 01010110 0", a_dr, in_ready);
        end
        #2 init_n = 1'b0;
        #1;
        checks++;
        if ({a_dr, b_dr, cin_dr} !== 18'h0) begin
            errors++; $display("FAIL areset_rails got a=%b b=%b cin=%b expected all 0", a_dr, b_dr, cin_dr);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL areset_flags got ready=%b busy=%b expected 1 0", in_ready, busy);
        end
        @(negedge clk);
        init_n = 1'b1;
        wait_neg(2);
    endtask

    task automatic test_err;
        logic exp_err;
`ifdef NCL_INJ_TIMEOUT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        in_valid = 1'b1; set_word(4'hC, 4'h1, 1'b0);
        wait_neg(1);
        in_valid = 1'b0;
        wait_neg(22);
        checks++;
        if (err !== exp_err || a_dr !== 8'b10100101) begin
            errors++; $display("FAIL err_timeout got err=%b a=%b expected %b 10100101", err, a_dr, exp_err);
        end
        drive_ack(1'b1);
        drive_ack(1'b0);
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL err_sticky got %b expected %b", err, exp_err); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_ack_high_at_reset();
        test_async_reset_in_data();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no completion expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
